// File: rtl/laser_cover_eval.sv
// Scores a solver result: snoops each 40-point frame into a ping-pong buffer, then on DONE
// rescans the oldest stored frame and counts points inside either of the two circles.
module laser_cover_eval #(
    parameter int NPTS = 40,
    parameter int RAD2 = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       DONE,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [5:0] COUNT,
    output logic       BUSY,
    output logic       ERR
);

    localparam logic [5:0] LAST_IDX = 6'(NPTS - 1);
    localparam logic [8:0] RAD2_W   = 9'(RAD2);

    typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, RESULT = 2'd2} state_t;

    function automatic logic covered_f(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sx;
        logic [7:0] sy;
        logic [8:0] sum;
        dx  = (px >= cx) ? (px - cx) : (cx - px);
        dy  = (py >= cy) ? (py - cy) : (cy - py);
        sx  = {4'd0, dx} * {4'd0, dx};
        sy  = {4'd0, dy} * {4'd0, dy};
        sum = {1'b0, sx} + {1'b0, sy};
        return (sum <= RAD2_W);
    endfunction

    state_t     state_r, state_next_s;
    logic       busy_r;
    logic [7:0] mem_r [2][NPTS];
    logic [1:0] full_r, full_next_s;
    logic       wbank_r, rbank_r;
    logic [5:0] widx_r, eidx_r;
    logic [5:0] cnt_r, count_r;
    logic       out_valid_r, err_r, pend_r;
    logic [3:0] c1x_r, c1y_r, c2x_r, c2y_r;
    logic [3:0] p1x_r, p1y_r, p2x_r, p2y_r;

    logic       wr_s, wr_last_s, drop_s;
    logic       start_s, resume_s, last_s, accept_s, pend_store_s, done_err_s;
    logic [7:0] pt_s;
    logic       cov_s;

    assign wr_s      = IN_VALID && !full_r[wbank_r];
    assign wr_last_s = wr_s && (widx_r == LAST_IDX);
    assign drop_s    = IN_VALID && full_r[wbank_r];
    assign pt_s      = mem_r[rbank_r][eidx_r];
    assign cov_s     = covered_f(pt_s[7:4], pt_s[3:0], c1x_r, c1y_r)
                     | covered_f(pt_s[7:4], pt_s[3:0], c2x_r, c2y_r);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = start_s ? EVAL : IDLE;
            EVAL:    state_next_s = last_s ? RESULT : EVAL;
            RESULT:  state_next_s = accept_s ? (resume_s ? EVAL : IDLE) : RESULT;
            default: state_next_s = IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        start_s      = 1'b0;
        done_err_s   = 1'b0;
        last_s       = 1'b0;
        accept_s     = 1'b0;
        resume_s     = 1'b0;
        pend_store_s = 1'b0;
        case (state_r)
            IDLE: begin
                start_s    = DONE && full_r[rbank_r];
                done_err_s = DONE && !full_r[rbank_r];
            end
            EVAL: begin
                last_s       = (eidx_r == LAST_IDX);
                pend_store_s = DONE;
            end
            RESULT: begin
                accept_s     = out_valid_r && OUT_READY;
                resume_s     = out_valid_r && OUT_READY && pend_r && full_r[rbank_r];
                pend_store_s = DONE;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // Release and completion always target different banks, so both apply in one cycle
    always_comb begin
        full_next_s = full_r;
        for (int b = 0; b < 2; b++) begin
            full_next_s[b] = (full_r[b] & ~(last_s & (rbank_r == 1'(b))))
                           | (wr_last_s & (wbank_r == 1'(b)));
        end
    end

    // Point storage (not reset)
    always_ff @(posedge CLK) begin
        if (wr_s) begin
            mem_r[wbank_r][widx_r] <= {X, Y};
        end
    end

    // Capture side and bank bookkeeping
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            full_r  <= 2'b00;
            wbank_r <= 1'b0;
            rbank_r <= 1'b0;
            widx_r  <= 6'd0;
            err_r   <= 1'b0;
        end else begin
            full_r <= full_next_s;
            if (wr_s) begin
                widx_r <= wr_last_s ? 6'd0 : (widx_r + 6'd1);
            end
            if (wr_last_s) begin
                wbank_r <= ~wbank_r;
            end
            if (last_s) begin
                rbank_r <= ~rbank_r;
            end
            if (drop_s || done_err_s || (pend_store_s && pend_r)) begin
                err_r <= 1'b1;
            end
        end
    end

    // Centre registers, pending slot, scan counters and result port
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_r      <= 1'b0;
            {c1x_r, c1y_r, c2x_r, c2y_r} <= 16'd0;
            {p1x_r, p1y_r, p2x_r, p2y_r} <= 16'd0;
            eidx_r      <= 6'd0;
            cnt_r       <= 6'd0;
            count_r     <= 6'd0;
            out_valid_r <= 1'b0;
        end else begin
            if (pend_store_s) begin
                pend_r <= 1'b1;
                {p1x_r, p1y_r, p2x_r, p2y_r} <= {C1X, C1Y, C2X, C2Y};
            end else if (resume_s) begin
                pend_r <= 1'b0;
            end
            if (start_s) begin
                {c1x_r, c1y_r, c2x_r, c2y_r} <= {C1X, C1Y, C2X, C2Y};
            end else if (resume_s) begin
                {c1x_r, c1y_r, c2x_r, c2y_r} <= {p1x_r, p1y_r, p2x_r, p2y_r};
            end
            if (start_s || resume_s) begin
                eidx_r <= 6'd0;
                cnt_r  <= 6'd0;
            end else if (state_r == EVAL) begin
                eidx_r <= eidx_r + 6'd1;
                cnt_r  <= cnt_r + {5'd0, cov_s};
            end
            if (last_s) begin
                count_r     <= cnt_r + {5'd0, cov_s};
                out_valid_r <= 1'b1;
            end else if (accept_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign OUT_VALID = out_valid_r;
    assign COUNT     = count_r;
    assign BUSY      = busy_r;
    assign ERR       = err_r;

endmodule

// File: tb/tb_laser_cover_eval.sv
// Directed bench for laser_cover_eval: hand-computed coverage counts, latency, backpressure,
// error flags and mid-evaluation reset.
module tb_laser_cover_eval;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IN_VALID = 1'b0;
    logic [3:0] X = 4'd0, Y = 4'd0;
    logic       DONE = 1'b0;
    logic [3:0] C1X = 4'd0, C1Y = 4'd0, C2X = 4'd0, C2Y = 4'd0;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic [5:0] COUNT;
    logic       BUSY;
    logic       ERR;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cyc = 0;

    laser_cover_eval dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .X(X), .Y(Y),
        .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .COUNT(COUNT),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Streams 40 points, even entries (xa,ya), odd entries (xb,yb); IN_VALID left high
    task automatic send_frame(input logic [3:0] xa, input logic [3:0] ya,
                              input logic [3:0] xb, input logic [3:0] yb);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            IN_VALID = 1'b1;
            X = (i % 2 == 0) ? xa : xb;
            Y = (i % 2 == 0) ? ya : yb;
        end
    endtask

    task automatic stop_in();
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] ax, input logic [3:0] ay,
                              input logic [3:0] bx, input logic [3:0] by);
        @(negedge CLK);
        DONE = 1'b1; C1X = ax; C1Y = ay; C2X = bx; C2Y = by;
        @(negedge CLK);
        DONE = 1'b0;
        done_cyc = cyc;
    endtask

    task automatic wait_result(input int start, input logic [5:0] exp_count, input string name);
        int n;
        n = 0;
        while (OUT_VALID !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: OUT_VALID=%b required 1", name, OUT_VALID);
        end else begin
            checks++;
            if (cyc - start !== 40) begin
                errors++;
                $display("FAIL %s latency: got %0d edges required 40", name, cyc - start);
            end
            checks++;
            if (COUNT !== exp_count) begin
                errors++;
                $display("FAIL %s count: got %0d required %0d", name, COUNT, exp_count);
            end
        end
    endtask

    task automatic accept(input string name);
        @(negedge CLK);
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        checks++;
        if (OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: OUT_VALID=%b required 0", name, OUT_VALID);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        checks += 4;
        if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset OUT_VALID: got %b required 0", OUT_VALID); end
        if (COUNT !== 6'd0)     begin errors++; $display("FAIL reset COUNT: got %0d required 0", COUNT); end
        if (BUSY !== 1'b0)      begin errors++; $display("FAIL reset BUSY: got %b required 0", BUSY); end
        if (ERR !== 1'b0)       begin errors++; $display("FAIL reset ERR: got %b required 0", ERR); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_single_hit();
        send_frame(4'd8, 4'd8, 4'd8, 4'd8);
        stop_in();
        pulse_done(4'd8, 4'd8, 4'd0, 4'd0);
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL single BUSY: got %b required 1", BUSY); end
        wait_result(done_cyc, 6'd40, "single");
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL single ERR: got %b required 0", ERR); end
        accept("single");
    endtask

    task automatic test_radius_boundary();
        send_frame(4'd4, 4'd0, 4'd3, 4'd3);
        stop_in();
        pulse_done(4'd0, 4'd0, 4'd15, 4'd15);
        wait_result(done_cyc, 6'd20, "boundary");
        accept("boundary");
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL boundary idle BUSY: got %b required 0", BUSY); end
    endtask

    task automatic test_overlap();
        send_frame(4'd5, 4'd5, 4'd5, 4'd5);
        stop_in();
        pulse_done(4'd3, 4'd5, 4'd7, 4'd5);
        wait_result(done_cyc, 6'd40, "overlap");
        accept("overlap");
    endtask

    task automatic test_back_to_back();
        int t_a;
        int h;
        send_frame(4'd0, 4'd0, 4'd0, 4'd0);
        send_frame(4'd15, 4'd15, 4'd15, 4'd15);
        stop_in();
        pulse_done(4'd0, 4'd0, 4'd0, 4'd0);
        t_a = done_cyc;
        repeat (5) @(negedge CLK);
        pulse_done(4'd15, 4'd15, 4'd15, 4'd15);
        wait_result(t_a, 6'd40, "b2b first");
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if (OUT_VALID !== 1'b1 || COUNT !== 6'd40 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL b2b hold[%0d]: valid=%b count=%0d busy=%b required 1/40/1",
                         i, OUT_VALID, COUNT, BUSY);
            end
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        h = cyc;
        checks++;
        if (OUT_VALID !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL b2b handshake: valid=%b busy=%b required 0/1", OUT_VALID, BUSY);
        end
        wait_result(h, 6'd40, "b2b second");
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL b2b ERR: got %b required 0", ERR); end
        accept("b2b second");
    endtask

    task automatic test_errors();
        int seen;
        pulse_done(4'd1, 4'd1, 4'd1, 4'd1);
        checks++;
        if (ERR !== 1'b1) begin errors++; $display("FAIL nofull ERR: got %b required 1", ERR); end
        seen = 0;
        repeat (50) begin
            @(negedge CLK);
            if (OUT_VALID === 1'b1 || BUSY === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL nofull activity: got %0d busy/valid cycles required 0", seen); end

        do_reset();
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL overflow pre ERR: got %b required 0", ERR); end
        send_frame(4'd1, 4'd1, 4'd1, 4'd1);
        send_frame(4'd10, 4'd10, 4'd10, 4'd10);
        send_frame(4'd0, 4'd0, 4'd0, 4'd0);
        stop_in();
        checks++;
        if (ERR !== 1'b1) begin errors++; $display("FAIL overflow ERR: got %b required 1", ERR); end
        pulse_done(4'd1, 4'd1, 4'd1, 4'd1);
        wait_result(done_cyc, 6'd40, "overflow frameA");
        accept("overflow frameA");
        pulse_done(4'd10, 4'd10, 4'd10, 4'd10);
        wait_result(done_cyc, 6'd40, "overflow frameB");
        accept("overflow frameB");
        checks++;
        if (ERR !== 1'b1) begin errors++; $display("FAIL sticky ERR: got %b required 1", ERR); end
    endtask

    task automatic test_reset_mid_eval();
        int seen;
        do_reset();
        send_frame(4'd2, 4'd2, 4'd2, 4'd2);
        stop_in();
        pulse_done(4'd2, 4'd2, 4'd0, 4'd0);
        repeat (20) @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || COUNT !== 6'd0 || BUSY !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL midreset outputs: valid=%b count=%0d busy=%b err=%b required all 0",
                     OUT_VALID, COUNT, BUSY, ERR);
        end
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        repeat (60) begin
            @(negedge CLK);
            if (OUT_VALID === 1'b1 || BUSY === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset residue: got %0d busy/valid cycles required 0", seen); end
        send_frame(4'd2, 4'd2, 4'd9, 4'd9);
        stop_in();
        pulse_done(4'd2, 4'd2, 4'd0, 4'd0);
        wait_result(done_cyc, 6'd20, "postreset");
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL postreset ERR: got %b required 0", ERR); end
        accept("postreset");
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_radius_boundary();
        test_overlap();
        test_back_to_back();
        test_errors();
        test_reset_mid_eval();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
